// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
//   - Arbiter state encodings (s_ARB_*) and the matching enum type.
//   - clog2 / idx_w helpers for sizing index fields.
//   - Default word length shared with uart_tx.
package uart_pkg;

  localparam logic [1:0] s_ARB_IDLE = 2'b00;
  localparam logic [1:0] s_ARB_WAIT = 2'b01;
  localparam logic [1:0] s_ARB_GAP  = 2'b10;

  localparam int c_DEF_WORD_LEN = 8;

  typedef enum logic [1:0] {
    ARB_IDLE = s_ARB_IDLE,
    ARB_WAIT = s_ARB_WAIT,
    ARB_GAP  = s_ARB_GAP
  } arb_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Index width that never collapses to zero bits.
  function automatic int idx_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of i_req searching
// upward from i_ptr, wrapping modulo p_N. Works for non-power-of-two p_N.
// Ports:
//   i_req   [p_N]  request vector
//   i_ptr   [c_W]  search start index (0..p_N-1)
//   o_idx   [c_W]  chosen index (0 when nothing requested)
//   o_valid        any request present
module rr_pick import uart_pkg::*; #(
  parameter  int p_N  = 4,
  localparam int c_W  = idx_w(p_N)
) (
  input  logic [p_N-1:0] i_req,
  input  logic [c_W-1:0] i_ptr,
  output logic [c_W-1:0] o_idx,
  output logic           o_valid
);

  localparam int c_SW = c_W + 1;

  logic [c_SW-1:0] w_sum;

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    w_sum   = '0;
    for (int off = p_N - 1; off >= 0; off--) begin
      w_sum = {1'b0, i_ptr} + c_SW'(off);
      if (w_sum >= c_SW'(p_N)) w_sum = w_sum - c_SW'(p_N);
      if (i_req[w_sum[c_W-1:0]]) begin
        o_idx   = w_sum[c_W-1:0];
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between p_NUM_REQ requesters.
// One word is accepted per grant; the frame is tracked to completion via the
// rising edge of i_tx_done, then an optional idle gap precedes re-arbitration.
// Optional feature macro: UART_ARB_TIMEOUT_EN (adds o_timeout and a watchdog
// in WAIT that abandons a frame after p_TIMEOUT cycles without a done edge).
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_req  / i_data     per-requester level request and flattened words
//   o_grant             one-hot 1-cycle pulse, word accepted
//   o_owner             current or last winner
//   o_busy              state is not IDLE
//   o_frame_done        1-cycle pulse on frame completion
//   o_tx_dv / o_tx_data to uart_tx
//   i_tx_done/i_tx_active from uart_tx
//   o_timeout           watchdog pulse (UART_ARB_TIMEOUT_EN only)
// States:
//   IDLE | waiting for a request while the transmitter is inactive
//   WAIT | word handed to uart_tx, waiting for the done edge
//   GAP  | idle spacing after a frame before re-arbitration
module uart_tx_arbiter import uart_pkg::*; #(
  parameter  int p_NUM_REQ    = 4,
  parameter  int p_WORD_LEN   = c_DEF_WORD_LEN,
  parameter  int p_GAP_CYCLES = 0,
  parameter  int p_TIMEOUT    = 4096,
  localparam int c_OW         = idx_w(p_NUM_REQ),
  localparam int c_DW         = p_WORD_LEN + 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [p_NUM_REQ-1:0]       i_req,
  input  logic [p_NUM_REQ*c_DW-1:0]  i_data,
  output logic [p_NUM_REQ-1:0]       o_grant,
  output logic [c_OW-1:0]            o_owner,
  output logic                       o_busy,
  output logic                       o_frame_done,
  output logic                       o_tx_dv,
  output logic [c_DW-1:0]            o_tx_data,
  input  logic                       i_tx_done,
  input  logic                       i_tx_active
`ifdef UART_ARB_TIMEOUT_EN
  ,
  output logic                       o_timeout
`endif
);

  arb_state_e           r_state, w_state_nxt;
  logic [c_OW-1:0]      r_ptr, w_ptr_nxt;
  logic [7:0]           r_gap_cnt, w_gap_nxt;
  logic                 r_done_d;
  logic [p_NUM_REQ-1:0] r_grant, w_grant_nxt;
  logic [c_OW-1:0]      r_owner, w_owner_nxt;
  logic                 r_frame_done, w_fd_nxt;
  logic                 r_tx_dv, w_dv_nxt;
  logic [c_DW-1:0]      r_tx_data, w_data_nxt;

  logic [c_OW-1:0]      w_pick_idx;
  logic                 w_pick_vld;
  logic [c_DW-1:0]      w_word;
  logic                 w_done_edge;
  logic [c_OW-1:0]      w_owner_inc;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int c_WDW = idx_w(p_TIMEOUT);
  logic [c_WDW-1:0]     r_wd_cnt, w_wd_nxt;
  logic                 r_timeout, w_to_nxt;
`endif

  rr_pick #(.p_N(p_NUM_REQ)) u_pick (
    .i_req   (i_req),
    .i_ptr   (r_ptr),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_vld)
  );

  assign w_word      = i_data[w_pick_idx*c_DW +: c_DW];
  assign w_done_edge = i_tx_done & ~r_done_d;
  assign w_owner_inc = (r_owner == c_OW'(p_NUM_REQ - 1)) ? '0 : r_owner + c_OW'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_gap_nxt   = r_gap_cnt;
    w_grant_nxt = '0;
    w_dv_nxt    = 1'b0;
    w_fd_nxt    = 1'b0;
    w_owner_nxt = r_owner;
    w_data_nxt  = r_tx_data;
`ifdef UART_ARB_TIMEOUT_EN
    w_wd_nxt    = r_wd_cnt;
    w_to_nxt    = 1'b0;
`endif
    case (r_state)
      ARB_IDLE: begin
        if (w_pick_vld && !i_tx_active) begin
          w_grant_nxt = {{(p_NUM_REQ-1){1'b0}}, 1'b1} << w_pick_idx;
          w_dv_nxt    = 1'b1;
          w_data_nxt  = w_word;
          w_owner_nxt = w_pick_idx;
          w_state_nxt = ARB_WAIT;
`ifdef UART_ARB_TIMEOUT_EN
          w_wd_nxt    = c_WDW'(p_TIMEOUT - 1);
`endif
        end
      end
      ARB_WAIT: begin
        if (w_done_edge) begin
          w_fd_nxt  = 1'b1;
          w_ptr_nxt = w_owner_inc;
          if (p_GAP_CYCLES > 0) begin
            w_state_nxt = ARB_GAP;
            w_gap_nxt   = 8'(p_GAP_CYCLES - 1);
          end else begin
            w_state_nxt = ARB_IDLE;
          end
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (r_wd_cnt == '0) begin
          // Abandon the frame: move on to the next requester silently.
          w_to_nxt    = 1'b1;
          w_ptr_nxt   = w_owner_inc;
          w_state_nxt = ARB_IDLE;
        end else begin
          w_wd_nxt = r_wd_cnt - c_WDW'(1);
        end
`endif
      end
      ARB_GAP: begin
        if (r_gap_cnt == 8'd0) w_state_nxt = ARB_IDLE;
        else                   w_gap_nxt   = r_gap_cnt - 8'd1;
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ARB_IDLE;
      r_ptr        <= '0;
      r_gap_cnt    <= '0;
      r_done_d     <= 1'b0;
      r_grant      <= '0;
      r_owner      <= '0;
      r_frame_done <= 1'b0;
      r_tx_dv      <= 1'b0;
      r_tx_data    <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      r_wd_cnt     <= '0;
      r_timeout    <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_ptr        <= w_ptr_nxt;
      r_gap_cnt    <= w_gap_nxt;
      r_done_d     <= i_tx_done;
      r_grant      <= w_grant_nxt;
      r_owner      <= w_owner_nxt;
      r_frame_done <= w_fd_nxt;
      r_tx_dv      <= w_dv_nxt;
      r_tx_data    <= w_data_nxt;
`ifdef UART_ARB_TIMEOUT_EN
      r_wd_cnt     <= w_wd_nxt;
      r_timeout    <= w_to_nxt;
`endif
    end
  end

  assign o_grant      = r_grant;
  assign o_owner      = r_owner;
  assign o_busy       = (r_state != ARB_IDLE);
  assign o_frame_done = r_frame_done;
  assign o_tx_dv      = r_tx_dv;
  assign o_tx_data    = r_tx_data;
`ifdef UART_ARB_TIMEOUT_EN
  assign o_timeout    = r_timeout;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int DW  = 9;
  localparam int GAP = 3;
  localparam int TO  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N*DW-1:0] data;
  logic [N-1:0]  grant;
  logic [1:0]    owner;
  logic          busy, fd, dv;
  logic [DW-1:0] txdata;
  logic          tx_done, tx_active;
`ifdef UART_ARB_TIMEOUT_EN
  logic          timeout;
`endif

  int n_vec = 0;
  int n_err = 0;
  int dv_total = 0;
  int fd_total = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .p_NUM_REQ(N), .p_WORD_LEN(8), .p_GAP_CYCLES(GAP), .p_TIMEOUT(TO)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_data(data),
    .o_grant(grant), .o_owner(owner), .o_busy(busy), .o_frame_done(fd),
    .o_tx_dv(dv), .o_tx_data(txdata), .i_tx_done(tx_done), .i_tx_active(tx_active)
`ifdef UART_ARB_TIMEOUT_EN
    , .o_timeout(timeout)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 = free, 1 = frame outstanding, 2 = spacing.
  int           m_ptr, m_phase, m_gap_left, m_elapsed;
  logic         m_prev_done, m_ready = 1'b0;
  logic [N-1:0] e_grant;
  logic         e_dv, e_fd, e_to;
  logic [DW-1:0] e_data;
  int           e_owner;

  always @(posedge clk) begin : model
    int win;
    win = -1;
    m_prev_done <= tx_done;
    e_grant <= '0; e_dv <= 1'b0; e_fd <= 1'b0; e_to <= 1'b0;
    if (rst) begin
      m_ptr <= 0; m_phase <= 0; m_gap_left <= 0; m_elapsed <= 0;
      m_prev_done <= 1'b0; e_owner <= 0; e_data <= '0; m_ready <= 1'b1;
    end else if (m_phase == 0) begin
      if (!tx_active) begin
        for (int off = 0; off < N; off++)
          if (win < 0 && req[(m_ptr + off) % N]) win = (m_ptr + off) % N;
        if (win >= 0) begin
          e_grant <= N'(1) << win; e_dv <= 1'b1;
          e_data <= data[win*DW +: DW]; e_owner <= win;
          m_phase <= 1; m_elapsed <= 0;
        end
      end
    end else if (m_phase == 1) begin
      if (tx_done && !m_prev_done) begin
        e_fd <= 1'b1; m_ptr <= (e_owner + 1) % N;
        m_phase <= (GAP > 0) ? 2 : 0; m_gap_left <= GAP;
      end
`ifdef UART_ARB_TIMEOUT_EN
      else if (m_elapsed + 1 == TO) begin
        e_to <= 1'b1; m_ptr <= (e_owner + 1) % N; m_phase <= 0;
      end
`endif
      else m_elapsed <= m_elapsed + 1;
    end else begin
      if (m_gap_left == 1) m_phase <= 0;
      m_gap_left <= m_gap_left - 1;
    end
  end

  always @(negedge clk) begin
    if (m_ready) begin
      chk("cyc_grant", 32'(grant), 32'(e_grant));
      chk("cyc_dv", 32'(dv), 32'(e_dv));
      chk("cyc_fd", 32'(fd), 32'(e_fd));
      chk("cyc_owner", 32'(owner), 32'(e_owner));
      chk("cyc_busy", 32'(busy), 32'(m_phase != 0));
      chk("cyc_data", 32'(txdata), 32'(e_data));
`ifdef UART_ARB_TIMEOUT_EN
      chk("cyc_timeout", 32'(timeout), 32'(e_to));
`endif
      if (dv) dv_total++;
      if (fd) fd_total++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(2); rst = 1'b0;
  endtask

  task automatic pulse_done();
    tx_done = 1'b1; tick(2); tx_done = 1'b0;
  endtask

  task automatic wait_dv(input int budget);
    int w;
    w = 0;
    while (!dv && w < budget) begin tick(1); w++; end
    chk("dv_within_budget", 32'(dv), 32'd1);
  endtask

  initial begin : stim
    int exp_order [5] = '{0, 1, 2, 3, 0};
    logic [DW-1:0] words [4] = '{9'h101, 9'h1A2, 9'h0C3, 9'h1F4};
    int cnt, g, dv0;
    rst = 1'b1; req = '0; data = '0; tx_done = 1'b0; tx_active = 1'b0;
    tick(3); rst = 1'b0; tick(1);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_data", 32'(txdata), 32'd0);

    // single requester
    data[0 +: DW] = 9'h0A5; req = 4'b0001; tick(1);
    chk("t1_grant", 32'(grant), 32'h1);
    chk("t1_dv", 32'(dv), 32'd1);
    chk("t1_data", 32'(txdata), 32'h0A5);
    chk("t1_busy", 32'(busy), 32'd1);
    req = '0; tick(1);
    chk("t1_dv_gone", 32'(dv), 32'd0);
    chk("t1_data_held", 32'(txdata), 32'h0A5);
    tick(3);
    cnt = 0; tx_done = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (i == 1) tx_done = 1'b0;
      if (fd) cnt++;
    end
    chk("t1_fd_once", 32'(cnt), 32'd1);
    chk("t1_idle", 32'(busy), 32'd0);

    // all four requesting
    do_reset();
    for (int k = 0; k < N; k++) data[k*DW +: DW] = words[k];
    req = 4'b1111; dv0 = dv_total;
    for (int f = 0; f < 5; f++) begin
      wait_dv(10);
      chk("t2_owner", 32'(owner), 32'(exp_order[f]));
      chk("t2_data", 32'(txdata), 32'(words[exp_order[f]]));
      if (f == 4) req = '0;
      tick(2); pulse_done();
    end
    tick(8);
    chk("t2_dv_count", 32'(dv_total - dv0), 32'd5);

    // pointer 2 with requests 0011
    do_reset();
    req = 4'b0010; wait_dv(5);
    chk("t3_first", 32'(owner), 32'd1);
    req = '0; tick(1); pulse_done(); tick(6);
    req = 4'b0011; wait_dv(5);
    chk("t3_wrap", 32'(grant), 32'b0001);
    tick(1); pulse_done(); wait_dv(10);
    chk("t3_next", 32'(owner), 32'd1);

    // gap of 3 between frame_done and next dv
    tick(1); tx_done = 1'b1; tick(1);
    chk("t4_fd", 32'(fd), 32'd1);
    g = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (i == 0) tx_done = 1'b0;
      if (dv) break;
      g++;
    end
    chk("t4_gap", 32'(g), 32'd3);
    chk("t4_owner", 32'(owner), 32'd0);
    req = '0; tick(1); pulse_done(); tick(6);

    // done in IDLE is ignored
    cnt = fd_total; pulse_done(); tick(3);
    chk("t4_idle_done", 32'(fd_total - cnt), 32'd0);

    // reset while a frame is outstanding
    req = 4'b0100; wait_dv(5);
    chk("t5_pre", 32'(owner), 32'd2);
    req = '0; tick(2);
    tx_active = 1'b1; rst = 1'b1; req = 4'b0110; tick(1); rst = 1'b0;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_owner", 32'(owner), 32'd0);
    chk("t5_data", 32'(txdata), 32'd0);
    cnt = dv_total; tick(5);
    chk("t5_no_grant_active", 32'(dv_total - cnt), 32'd0);
    tx_active = 1'b0; wait_dv(5);
    chk("t5_ptr_cleared", 32'(owner), 32'd1);
    req = '0; tick(1); pulse_done(); tick(6);

`ifdef UART_ARB_TIMEOUT_EN
    req = 4'b0011; wait_dv(5);
    chk("t6_owner", 32'(owner), 32'd0);
    g = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1); g++;
      if (timeout) break;
    end
    chk("t6_timeout_cycles", 32'(g), 32'd16);
    wait_dv(5);
    chk("t6_next", 32'(owner), 32'd1);
    req = '0; tick(1); pulse_done(); tick(6);
`else
    req = 4'b0001; wait_dv(5); req = '0;
    tick(40);
    chk("t6_waits", 32'(busy), 32'd1);
    pulse_done(); tick(6);
    chk("t6_released", 32'(busy), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench did not finish");
  end

endmodule
